fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 82 ++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect control and the
// valid/ready handoff toward decode.
interface fetch_unit_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16
);
  logic               fetch_en;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               id_ready;

  // Fetch unit side
  modport slave (
    input  fetch_en, redirect, redirect_pc, imem_instr, id_ready,
    output imem_addr, if_valid, if_instr, if_pc
  );

  // Pipeline control / memory / decode side
  modport master (
    output fetch_en, redirect, redirect_pc, imem_instr, id_ready,
    input  imem_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register driving a combinational instruction
// memory, feeding a 2-entry {pc, instr} queue toward decode. Redirect
// flushes the queue and reloads the PC.
module fetch_unit #(
  parameter int ADDR_W   = 4,
  parameter int INSTR_W  = 16,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.slave  bus
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_count;
  entry_t            r_q0;    // head
  entry_t            r_q1;    // tail when two entries are held

  logic   w_valid;
  logic   w_pop;
  logic   w_push;
  entry_t w_new;

  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_valid && bus.id_ready;
  // A full queue can still accept when the head leaves this cycle.
  assign w_push  = bus.fetch_en && !bus.redirect && ((r_count != 2'd2) || w_pop);
  assign w_new   = {r_pc, bus.imem_instr};

  // PC and queue update; redirect overrides push and pop alike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= ADDR_W'(RESET_PC);
      r_count <= 2'd0;
      r_q0    <= '0;
      r_q1    <= '0;
    end else if (bus.redirect) begin
      r_pc    <= bus.redirect_pc;
      r_count <= 2'd0;
      r_q0    <= '0;
      r_q1    <= '0;
    end else begin
      // PC wraps naturally at 2^ADDR_W by truncation.
      if (w_push) r_pc <= r_pc + ADDR_W'(PC_STEP);
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_q0 <= w_new;
          else                 r_q1 <= w_new;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_q0    <= r_q1;
          r_q1    <= '0;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_q0 <= r_q1;
            r_q1 <= w_new;
          end else begin
            r_q0 <= w_new;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory address comes straight from the PC register, so id_ready never
  // reaches it combinationally.
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = w_valid;
  assign bus.if_instr  = w_valid ? r_q0.instr : '0;
  assign bus.if_pc     = w_valid ? r_q0.pc    : '0;

endmodule
